// File: rtl/matrix_arbiter_n_pkg.sv
// Shared helpers for the N-way least-recently-granted matrix arbiter.
// Holds the triangle index mapping and the one-hot to binary encoder.
package matrix_arbiter_n_pkg;

  localparam int MAX_N = 64;

  // Pair (i, j) with i > j maps onto a packed lower-triangle bit.
  function automatic int tri_idx(input int i, input int j);
    return (i * (i - 1)) / 2 + j;
  endfunction

  // OR of set-bit indices; exact for one-hot or all-zero input.
  function automatic int onehot2idx(input logic [MAX_N-1:0] v);
    int r;
    r = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (v[i]) r = r | i;
    end
    return r;
  endfunction

endpackage

// File: rtl/matrix_arbiter_n_if.sv
// Request/grant bundle between N requesters and the arbiter.
// The master side drives requests and downstream ready; the slave side is the arbiter.
interface matrix_arbiter_n_if #(
  parameter int N = 5
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]     req;
  logic [N-1:0]     req_last;
  logic             out_ready;
  logic [N-1:0]     gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;

  modport master (
    output req, req_last, out_ready,
    input  gnt, gnt_idx, gnt_valid
  );

  modport slave (
    input  req, req_last, out_ready,
    output gnt, gnt_idx, gnt_valid
  );
endinterface

// File: rtl/matrix_arbiter_n_prio_matrix.sv
// Triangle-stored priority matrix: bit p[i][j] (i > j) set means i beats j.
// Produces the combinational winner among eligible requesters and ages the winner on update.
module matrix_arbiter_n_prio_matrix
  import matrix_arbiter_n_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         upd_en,
  input  logic [N-1:0] upd_onehot,
  input  logic [N-1:0] elig,
  output logic [N-1:0] win
);

  localparam int NP = (N * (N - 1)) / 2;

  logic [NP-1:0] tri_q;

  always_comb begin
    logic ok;
    win = '0;
    for (int k = 0; k < N; k++) begin
      ok = elig[k];
      for (int j = 0; j < N; j++) begin
        if (j != k && elig[j]) begin
          if (k > j) ok = ok & tri_q[tri_idx(k, j)];
          else       ok = ok & ~tri_q[tri_idx(j, k)];
        end
      end
      win[k] = ok;
    end
  end

  // The just-granted requester drops below every other requester.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tri_q <= '1;
    end else if (upd_en) begin
      for (int i = 1; i < N; i++) begin
        for (int j = 0; j < i; j++) begin
          if (upd_onehot[i])      tri_q[tri_idx(i, j)] <= 1'b0;
          else if (upd_onehot[j]) tri_q[tri_idx(i, j)] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/matrix_arbiter_n.sv
// N-way least-recently-granted arbiter with registered one-hot grant held across stalls.
// Define ARB_PKT_LOCK_EN to keep a grant on its requester until the final beat of a packet.
module matrix_arbiter_n
  import matrix_arbiter_n_pkg::*;
#(
  parameter int N = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  matrix_arbiter_n_if.slave   bus
);

  localparam int IDX_W = $clog2(N);

  logic         xfer;
  logic         load;
  logic         cont;
  logic [N-1:0] mask;
  logic [N-1:0] elig;
  logic [N-1:0] win;
  logic [N-1:0] win_sel;
  logic         upd_en;

  assign xfer = bus.gnt_valid & bus.out_ready;
  assign load = ~bus.gnt_valid | xfer;

`ifdef ARB_PKT_LOCK_EN
  logic nonfinal;

  // A non-final beat keeps its owner eligible and, if still requesting, re-granted without aging.
  always_comb begin
    nonfinal = xfer & (|(bus.gnt & ~bus.req_last));
    cont     = nonfinal & (|(bus.gnt & bus.req));
    mask     = (xfer & ~nonfinal) ? bus.gnt : '0;
  end
`else
  logic unused_req_last;

  assign unused_req_last = ^bus.req_last;

  always_comb begin
    cont = 1'b0;
    mask = xfer ? bus.gnt : '0;
  end
`endif

  always_comb begin
    elig    = bus.req & ~mask;
    win_sel = cont ? bus.gnt : win;
    upd_en  = load & ~cont & (|win);
  end

  matrix_arbiter_n_prio_matrix #(
    .N (N)
  ) u_prio (
    .clk        (clk),
    .rst_n      (rst_n),
    .upd_en     (upd_en),
    .upd_onehot (win),
    .elig       (elig),
    .win        (win)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.gnt       <= '0;
      bus.gnt_idx   <= '0;
      bus.gnt_valid <= 1'b0;
    end else if (load) begin
      bus.gnt       <= win_sel;
      bus.gnt_idx   <= IDX_W'(onehot2idx(MAX_N'(win_sel)));
      bus.gnt_valid <= |elig;
    end
  end

endmodule

// File: tb/tb_matrix_arbiter_n.sv
// Bench for matrix_arbiter_n at N=5, 2 and 8 against a timestamp-based LRG model.
// Directed literal checks pin the model; random phases exercise stalls, fairness and resets.
module tb_matrix_arbiter_n;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  matrix_arbiter_n_if #(.N(5)) b5 ();
  matrix_arbiter_n_if #(.N(2)) b2 ();
  matrix_arbiter_n_if #(.N(8)) b8 ();

  matrix_arbiter_n #(.N(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(b5));
  matrix_arbiter_n #(.N(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
  matrix_arbiter_n #(.N(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

  int total = 0;
  int bad = 0;
  int nn[3] = '{5, 2, 8};
  int stamp[3][8];
  int tick[3];
  int mg[3];
  bit check_en = 1'b0;
  bit rec_en = 1'b0;
  int hist[3][$];

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endfunction

  // Lower stamp = granted longer ago = wins; reset order has the highest index oldest.
  function automatic void model_reset(input int u);
    for (int i = 0; i < 8; i++) stamp[u][i] = -(i + 1);
    tick[u] = 0;
    mg[u] = -1;
  endfunction

  function automatic void model_step(input int u, input logic [7:0] r,
                                     input logic [7:0] l, input logic rdy);
    bit valid;
    bit xf;
    bit keep;
    logic [7:0] e;
    int best;
    valid = (mg[u] >= 0);
    xf = valid && rdy;
    keep = 1'b0;
    e = r;
    best = -1;
    if (valid && !xf) return;
    if (xf) begin
      if (rec_en) hist[u].push_back(mg[u]);
`ifdef ARB_PKT_LOCK_EN
      if (!l[mg[u]]) keep = r[mg[u]];
      else e[mg[u]] = 1'b0;
`else
      if (l[0] === 1'bx) keep = 1'b0;
      e[mg[u]] = 1'b0;
`endif
    end
    if (keep) return;
    for (int k = 0; k < nn[u]; k++) begin
      if (e[k] && (best < 0 || stamp[u][k] < stamp[u][best])) best = k;
    end
    mg[u] = best;
    if (best >= 0) begin
      tick[u]++;
      stamp[u][best] = tick[u];
    end
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int u = 0; u < 3; u++) model_reset(u);
      check_en = 1'b1;
    end else begin
      model_step(0, 8'(b5.req), 8'(b5.req_last), b5.out_ready);
      model_step(1, 8'(b2.req), 8'(b2.req_last), b2.out_ready);
      model_step(2, 8'(b8.req), 8'(b8.req_last), b8.out_ready);
    end
  end

  function automatic void cmp_inst(input int u, input logic [7:0] g, input int idx, input logic v);
    int eg;
    eg = (mg[u] >= 0) ? (1 << mg[u]) : 0;
    check($sformatf("n%0d_gnt", nn[u]), int'(g), eg);
    check($sformatf("n%0d_idx", nn[u]), idx, (mg[u] >= 0) ? mg[u] : 0);
    check($sformatf("n%0d_valid", nn[u]), int'(v), (mg[u] >= 0) ? 1 : 0);
    check($sformatf("n%0d_onehot0", nn[u]), int'($onehot0(g)), 1);
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      cmp_inst(0, 8'(b5.gnt), int'(b5.gnt_idx), b5.gnt_valid);
      cmp_inst(1, 8'(b2.gnt), int'(b2.gnt_idx), b2.gnt_valid);
      cmp_inst(2, 8'(b8.gnt), int'(b8.gnt_idx), b8.gnt_valid);
    end
  end

  task automatic idle_inputs();
    b5.req = '0; b5.req_last = '0; b5.out_ready = 1'b0;
    b2.req = '0; b2.req_last = '0; b2.out_ready = 1'b0;
    b8.req = '0; b8.req_last = '0; b8.out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int e1[6];
    int e5[4];
    logic [7:0] seen;
    int nb;
    e1 = '{4, 3, 2, 1, 0, 4};
`ifdef ARB_PKT_LOCK_EN
    e5 = '{1, 1, 1, 0};
`else
    e5 = '{1, 0, 1, 0};
`endif
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", int'(b5.gnt_valid), 0);
    check("rst_gnt", int'(b5.gnt), 0);
    check("rst_idx", int'(b5.gnt_idx), 0);

    // all five requesting from reset: rotate down from the highest index
    rst_n = 1'b1;
    b5.req = 5'b11111;
    b5.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_idx", int'(b5.gnt_idx), e1[i]);
      check("t1_valid", int'(b5.gnt_valid), 1);
    end
    idle_inputs();
    pulse_reset();

    // stalled grant ignores request changes
    b5.req = 5'b10000;
    @(negedge clk);
    check("t2_gnt_first", int'(b5.gnt), 16);
    b5.req = 5'b00001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_gnt_hold", int'(b5.gnt), 16);
    end
    b5.out_ready = 1'b1;
    @(negedge clk);
    check("t2_gnt_next", int'(b5.gnt), 1);
    b5.req = '0;
    @(negedge clk);
    idle_inputs();
    pulse_reset();

    // lone requester gets every other cycle
    b5.req = 5'b00100;
    b5.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_valid", int'(b5.gnt_valid), (i % 2 == 0) ? 1 : 0);
      check("t3_idx", int'(b5.gnt_idx), (i % 2 == 0) ? 2 : 0);
    end
    idle_inputs();
    pulse_reset();

    // reset mid-stream restores default priority
    b5.req = 5'b11111;
    b5.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_busy", int'(b5.gnt_idx), 3);
    rst_n = 1'b0;
    @(negedge clk);
    check("t4_rst_valid", int'(b5.gnt_valid), 0);
    check("t4_rst_gnt", int'(b5.gnt), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("t4_first", int'(b5.gnt_idx), 4);
    idle_inputs();
    @(negedge clk);
    pulse_reset();

    // multi-beat packet from requester 1
    b5.req = 5'b00011;
    b5.req_last = 5'b00000;
    b5.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) b5.req_last = 5'b00010;
      @(negedge clk);
      check("t5_idx", int'(b5.gnt_idx), e5[i]);
    end
    idle_inputs();
    @(negedge clk);
    pulse_reset();

    // fairness with everyone requesting and random stalls
    for (int u = 0; u < 3; u++) hist[u].delete();
    rec_en = 1'b1;
    b5.req = '1; b5.req_last = '1;
    b2.req = '1; b2.req_last = '1;
    b8.req = '1; b8.req_last = '1;
    for (int c = 0; c < 600; c++) begin
      b5.out_ready = 1'($urandom_range(0, 1));
      b2.out_ready = 1'($urandom_range(0, 1));
      b8.out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    rec_en = 1'b0;
    for (int u = 0; u < 3; u++) begin
      nb = hist[u].size() / nn[u];
      check($sformatf("n%0d_fair_enough", nn[u]), int'(nb >= 10), 1);
      for (int b = 0; b < nb; b++) begin
        seen = '0;
        for (int t = 0; t < nn[u]; t++) seen[hist[u][b * nn[u] + t]] = 1'b1;
        check($sformatf("n%0d_fair_block", nn[u]), int'(seen), (1 << nn[u]) - 1);
      end
    end
    idle_inputs();
    pulse_reset();

    // fully random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      b5.req = 5'($urandom); b5.req_last = 5'($urandom);
      b5.out_ready = 1'($urandom_range(0, 3) != 0);
      b2.req = 2'($urandom); b2.req_last = 2'($urandom);
      b2.out_ready = 1'($urandom_range(0, 1));
      b8.req = 8'($urandom); b8.req_last = 8'($urandom);
      b8.out_ready = 1'($urandom_range(0, 3) != 0);
      rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    rst_n = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
